// File: rtl/gpio_bus_pkg.sv
// Shared field positions of the 32-bit PS GPIO word and the register map
// used by the lock-in/OPO control registers.
package gpio_bus_pkg;

  localparam int GPIO_W_CLK_BIT  = 24;
  localparam int GPIO_DATA_MSB   = 23;
  localparam int GPIO_DATA_LSB   = 16;
  localparam int GPIO_ADDR_MSB   = 15;
  localparam int GPIO_ADDR_LSB   = 0;
  localparam int GPIO_ADDR_WIDTH = 16;
  localparam int GPIO_DATA_WIDTH = 8;

  localparam int REG_USER_CNTR  = 0;
  localparam int REG_SINC_IN    = 1;
  localparam int REG_INC_IN     = 2;
  localparam int REG_MUL_SCALAR = 3;

  // A single-byte register still reserves one lane address bit.
  function automatic int lane_bits(input int width);
    int bytes;
    bytes = width / 8;
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage synchroniser for the PS GPIO word with a rising-edge
// detector on one selected bit of the last stage.
module gpio_sync_edge #(
  parameter int WIDTH      = 32,
  parameter int STAGES     = 2,
  parameter int EDGE_BIT   = 24,
  parameter bit RESET_ONES = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             write_evt_o
);

  localparam logic [WIDTH-1:0] RST_WORD = RESET_ONES ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] stage_q [STAGES];
  logic             edge_prev_q;

  // Resetting to ones makes a strobe held high across reset look "old".
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= RST_WORD;
      end
      edge_prev_q <= RESET_ONES;
    end else begin
      stage_q[0] <= async_i;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
      edge_prev_q <= stage_q[STAGES-1][EDGE_BIT];
    end
  end

  assign sync_o      = stage_q[STAGES-1];
  assign write_evt_o = stage_q[STAGES-1][EDGE_BIT] & ~edge_prev_q;

endmodule

// File: rtl/gpio_reg_bank.sv
// Byte-wide GPIO write port assembling NUM_REGS registers that commit
// atomically on their top-lane write, with readback and error counters.
module gpio_reg_bank
  import gpio_bus_pkg::*;
#(
  parameter int                   NUM_REGS    = 4,
  parameter int                   REG_WIDTH   = 32,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [REG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [31:0]                   gpio_in,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]           reg_strobe,
  output logic [7:0]                    gpio_rdata,
  output logic                          addr_err,
  output logic [7:0]                    err_count,
  output logic [15:0]                   wr_count
);

  localparam int BYTES     = REG_WIDTH / 8;
  localparam int LANE_BITS = lane_bits(REG_WIDTH);
  localparam int IDX_W     = GPIO_ADDR_WIDTH - LANE_BITS;
  localparam int SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [31:0]                  sync_word;
  logic                         write_evt;
  logic [GPIO_DATA_WIDTH-1:0]   wdata;
  logic [GPIO_ADDR_WIDTH-1:0]   waddr;
  logic [LANE_BITS-1:0]         lane;
  logic [IDX_W-1:0]             idx;
  logic [SEL_W-1:0]             rd_sel;
  logic                         idx_valid;
  logic                         is_commit;
  logic                         accept;
  logic                         reject;
  logic                         unused_sync_bits;

  gpio_sync_edge #(
    .WIDTH      (32),
    .STAGES     (SYNC_STAGES),
    .EDGE_BIT   (GPIO_W_CLK_BIT),
    .RESET_ONES (1'b1)
  ) u_sync (
    .clk         (clk),
    .rstn        (rstn),
    .async_i     (gpio_in),
    .sync_o      (sync_word),
    .write_evt_o (write_evt)
  );

  assign wdata            = sync_word[GPIO_DATA_MSB:GPIO_DATA_LSB];
  assign waddr            = sync_word[GPIO_ADDR_MSB:GPIO_ADDR_LSB];
  assign unused_sync_bits = ^sync_word[31:GPIO_W_CLK_BIT];
  assign lane             = waddr[LANE_BITS-1:0];
  assign idx              = waddr[GPIO_ADDR_WIDTH-1:LANE_BITS];
  assign rd_sel           = idx[SEL_W-1:0];
  assign idx_valid        = (idx < IDX_W'(NUM_REGS));
  assign is_commit        = (lane == LANE_BITS'(BYTES - 1));
  assign accept           = write_evt & idx_valid;
  assign reject           = write_evt & ~idx_valid;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [BYTES-1:0][7:0] shadow_q;
    logic [BYTES-1:0][7:0] shadow_d;
    logic [BYTES-1:0][7:0] value_q;
    logic                  strobe_q;
    logic                  hit;

    assign hit = accept && (idx == IDX_W'(gi));

    // The committed word is the shadow with the incoming lane merged in.
    always_comb begin
      shadow_d       = shadow_q;
      shadow_d[lane] = wdata;
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        shadow_q <= '0;
        value_q  <= RESET_VALUE;
        strobe_q <= 1'b0;
      end else begin
        strobe_q <= hit && is_commit;
        if (hit) begin
          shadow_q <= shadow_d;
          if (is_commit) begin
            value_q <= shadow_d;
          end
        end
      end
    end

    assign reg_out[gi*REG_WIDTH +: REG_WIDTH] = value_q;
    assign reg_strobe[gi]                     = strobe_q;
  end

  logic [NUM_REGS-1:0][BYTES-1:0][7:0] committed;
  logic [7:0]                          rdata_d;
  logic [7:0]                          rdata_q;
  logic                                addr_err_q;
  logic [7:0]                          err_count_q;
  logic [15:0]                         wr_count_q;

  assign committed = reg_out;

  // Readback only ever exposes committed values, never the shadow.
  always_comb begin
    rdata_d = '0;
    if (idx_valid) begin
      rdata_d = committed[rd_sel][lane];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q     <= '0;
      addr_err_q  <= 1'b0;
      err_count_q <= '0;
      wr_count_q  <= '0;
    end else begin
      rdata_q    <= rdata_d;
      addr_err_q <= reject;
      if (reject && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (accept) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign gpio_rdata = rdata_q;
  assign addr_err   = addr_err_q;
  assign err_count  = err_count_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_gpio_reg_bank.sv
// Directed and randomized checks of gpio_reg_bank against a behavioural
// register-map model (4 x 32-bit registers, 2 sync stages).
module tb_gpio_reg_bank;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  gpio_in;
  logic [127:0] reg_out;
  logic [3:0]   reg_strobe;
  logic [7:0]   gpio_rdata;
  logic         addr_err;
  logic [7:0]   err_count;
  logic [15:0]  wr_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg    [4];
  logic [31:0] m_shadow [4];
  logic [7:0]  m_err;
  logic [15:0] m_wr;
  logic [15:0] wr_before;

  gpio_reg_bank dut (
    .clk        (clk),
    .rstn       (rstn),
    .gpio_in    (gpio_in),
    .reg_out    (reg_out),
    .reg_strobe (reg_strobe),
    .gpio_rdata (gpio_rdata),
    .addr_err   (addr_err),
    .err_count  (err_count),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_vec();
    return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  function automatic logic [7:0] exp_rdata(input logic [15:0] addr);
    int idx;
    idx = int'(addr >> 2);
    if (idx >= 4) return 8'h00;
    return 8'((m_reg[idx] >> (8 * int'(addr[1:0]))) & 32'hFF);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 4; r++) begin
      m_reg[r]    = '0;
      m_shadow[r] = '0;
    end
    m_err = '0;
    m_wr  = '0;
  endtask

  task automatic check_reset_state();
    chk("rst_reg_out", reg_out, model_vec());
    chk("rst_strobe", reg_strobe, 4'b0000);
    chk("rst_addr_err", addr_err, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_wr_count", wr_count, 16'd0);
    chk("rst_rdata", gpio_rdata, 8'h00);
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m_reset();
    check_reset_state();
  endtask

  // Present addr/data with w_clk low long enough for readback to settle.
  task automatic set_addr(input logic [15:0] addr, input logic [7:0] data);
    gpio_in = {8'h00, data, addr};
    @(negedge clk);
    chk("strobe_idle", reg_strobe, 4'b0000);
    chk("err_idle", addr_err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rdata", gpio_rdata, exp_rdata(addr));
  endtask

  // One host write; w_clk is left high for the caller (hold = extra cycles).
  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
    int         idx;
    int         lane;
    logic [3:0] exp_strobe;
    logic       exp_err;
    set_addr(addr, data);
    gpio_in[24] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reg_out_pre", reg_out, model_vec());
    chk("strobe_pre", reg_strobe, 4'b0000);
    idx        = int'(addr >> 2);
    lane       = int'(addr[1:0]);
    exp_strobe = 4'b0000;
    exp_err    = 1'b0;
    if (idx < 4) begin
      m_shadow[idx][lane*8 +: 8] = data;
      if (lane == 3) begin
        m_reg[idx] = m_shadow[idx];
        exp_strobe = 4'b0001 << idx;
      end
      m_wr = m_wr + 16'd1;
    end else begin
      exp_err = 1'b1;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end
    @(negedge clk);
    chk("reg_out", reg_out, model_vec());
    chk("strobe", reg_strobe, exp_strobe);
    chk("addr_err", addr_err, exp_err);
    chk("err_count", err_count, m_err);
    chk("wr_count", wr_count, m_wr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_strobe", reg_strobe, 4'b0000);
      chk("hold_err", addr_err, 1'b0);
      chk("hold_wr_count", wr_count, m_wr);
    end
  endtask

  initial begin
    rstn    = 1'b0;
    gpio_in = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    check_reset_state();

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_strobe", reg_strobe, 4'b0000);
      chk("idle_err", addr_err, 1'b0);
      chk("idle_wr_count", wr_count, 16'd0);
    end

    do_write(16'd8,  8'hEF, 0);
    do_write(16'd9,  8'hBE, 0);
    do_write(16'd10, 8'hAD, 0);
    chk("reg2_uncommitted", reg_out[95:64], 32'h0);
    do_write(16'd11, 8'hDE, 0);
    chk("reg2_commit", reg_out[95:64], 32'hDEADBEEF);
    chk("reg2_strobe", reg_strobe, 4'b0100);
    chk("wr_count_4", wr_count, 16'd4);

    do_write(16'd11, 8'h12, 0);
    chk("reg2_shadow_kept", reg_out[95:64], 32'h12ADBEEF);
    set_addr(16'd9, 8'h00);
    chk("rdata_addr9", gpio_rdata, 8'hBE);

    do_write(16'd16, 8'h55, 0);
    chk("inv_addr_err", addr_err, 1'b1);
    chk("inv_err_count", err_count, 8'd1);
    chk("inv_wr_count", wr_count, 16'd5);

    for (int k = 0; k < 300; k++) begin
      do_write(16'($urandom_range(16, 65535)), 8'($urandom), 0);
    end
    chk("err_saturated", err_count, 8'd255);

    wr_before = m_wr;
    do_write(16'd0, 8'h11, 50);
    chk("hold_single_write", wr_count, wr_before + 16'd1);

    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("wclk_high_no_wr", wr_count, 16'd0);
      chk("wclk_high_no_strobe", reg_strobe, 4'b0000);
      chk("wclk_high_reg_out", reg_out, 128'd0);
    end
    do_write(16'd3, 8'h77, 0);
    chk("post_rst_reg0", reg_out[31:0], 32'h77000000);
    chk("post_rst_wr_count", wr_count, 16'd1);

    do_write(16'd4, 8'h01, 0);
    do_write(16'd5, 8'h02, 0);
    do_write(16'd6, 8'h03, 0);
    apply_reset();
    do_write(16'd7, 8'hAA, 0);
    chk("partial_discard", reg_out[63:32], 32'hAA000000);

    for (int k = 0; k < 80; k++) begin
      do_write(16'($urandom_range(0, 23)), 8'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
